video_out_timing: RTL and testbench
===================================

# video_out_timing

Display-side consumer of the aligned pixel stream, in the `video_clk` domain. It buffers aligned RGB565 line bursts in a local FIFO and regenerates continuous display timing (HS/VS/DE) with 24-bit RGB. Timing locks to the upstream end-of-frame pulse. It feeds the HDMI/DVI encoder.

## Interface
- `H_DISP`, 1280, active pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 110 / 40 / 220, horizontal porches and sync in pixels
- `V_DISP`, 720, active lines
- `V_FP` / `V_SYNC` / `V_BP`, 5 / 5 / 20, vertical porches and sync in lines
- `HS_POL` / `VS_POL`, 1 / 1, asserted sync level
- `FIFO_DEPTH`, 2048, local buffer depth in words (power of two, ≥ `H_DISP`)

Ports:
- `video_clk`  in  1  pixel clock
- `rst`  in  1  reset; asynchronous, active-high
- `in_data`  in  16  aligned pixel, RGB565
- `in_valid`  in  1  `in_data` qualifier; one word per cycle
- `in_vs`  in  1  one-cycle pulse marking end of an upstream frame
- `test_en`  in  1  colour-bar select (see Configuration)
- `vid_rgb`  out  24  {R8,G8,B8}
- `vid_hs` / `vid_vs` / `vid_de`  out  1  display sync and data enable
- `locked`  out  1  timing running
- `underflow` / `overflow` / `sync_err`  out  1  sticky error flags
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  buffered word count

## Operation
- Totals: H_TOT = sum of the H parameters (1650); V_TOT = sum of the V parameters (750).
- Counters `hc` (0..H_TOT-1) and `vc` (0..V_TOT-1).
- Active region: `hc<H_DISP && vc<V_DISP`.
- HS is asserted for `hc` in [H_DISP+H_FP, H_DISP+H_FP+H_SYNC). VS uses the same form on `vc`.
- FSM `WAIT`:
  - counters held at 0, `locked`=0, sync outputs deasserted, `vid_de`=0;
  - `in_valid` words are discarded and the FIFO is kept empty;
  - on `in_vs` it loads `hc`=0 and `vc`=V_DISP and moves to `RUN`. The frame starts in vertical blanking so the next upstream frame can fill the FIFO.
- FSM `RUN`:
  - counters free-run and `locked`=1;
  - `in_valid` words are written to the FIFO;
  - on `in_vs` with `vc`≠V_DISP-1 or `hc`≠H_TOT-1, `sync_err` is set and the counters are reloaded as above without a FIFO flush. An `in_vs` exactly at the frame boundary is the normal case.
- Read side:
  - `rd_en` = active & ~empty.
  - If active & empty, `underflow` is set and the output pixel is 0x000000.
- Write side: `in_valid` while full drops the word and sets `overflow`.
- Simultaneous read and write: `fifo_level` is unchanged.
- RGB expansion: R={r5,r5[4:2]}, G={g6,g6[5:4]}, B={b5,b5[4:2]}.
- Error flags are cleared only by `rst`.

## Timing
- Output latency is 2 cycles from the counter state: FIFO registered read, then the output register. HS/VS/DE are delayed by 2 cycles to match.
- The first active pixel of a locked frame appears on `vid_rgb` 2 cycles after the cycle where `hc`=0 and `vc`=0.
- Reset values:
  - `vid_rgb`=0, `vid_de`=0;
  - `vid_hs`=~HS_POL, `vid_vs`=~VS_POL;
  - `locked`=0, all flags 0, `fifo_level`=0;
  - FSM=`WAIT`.
- Wrap: `hc`=H_TOT-1 → 0 and `vc` increments; `vc`=V_TOT-1 → 0.
- Reset mid-frame: all outputs return to reset values within the same cycle (asynchronous), and the FIFO is emptied.

## Configuration
- `VID_OUT_TESTPAT_EN` defined:
  - `test_en`=1 replaces FIFO data with 8 equal-width vertical colour bars (white, yellow, cyan, green, magenta, red, blue, black) across H_DISP;
  - the FIFO is not read in this mode, so `underflow` cannot set;
  - timing is unchanged, and the bars are emitted in `WAIT` with the counters free-running (`locked` stays 0).
- Not defined: `test_en` is ignored and there is no pattern logic.

## Structure
- Package `video_pkg`:
  - 720p timing defaults;
  - the `rgb565_to_888` function;
  - colour-bar constants;
  - the FSM state enum.
- One sub-module, `sync_fifo`: single clock, registered read, count output, synchronous flush.

## Test plan
- **Reset, no stream:** `locked`=0, `vid_de`=0, `vid_hs`=0 with HS_POL=1, `vid_rgb`=0.
- **Lock and replay:**
  - stimulus: `in_vs` pulse, then 720 bursts of 1280 words each `{R5=i[4:0],G=0,B=0}`, then `in_vs`;
  - required: 750 lines of 1650 clocks, 1280 DE clocks per line, pixel matches the written word expanded, no flags set.
- **Starved line:** only 1000 words supplied for line 0 → pixels 1000..1279 are 0, `underflow`=1 and stays 1.
- **Overflow:** 2049 writes with no reads in `WAIT`→`RUN` blanking → `fifo_level`=2048, `overflow`=1.
- **Early `in_vs`:** `in_vs` at `vc`=100 → `sync_err`=1, next cycle `vc`=720 and `hc`=0.
- **Test pattern (macro defined):** `test_en`=1 → pixel 0 = 0xFFFFFF, pixel 160 = 0xFFFF00, pixel 1279 = 0x000000.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg: shared definitions for the display timing block.
// 720p timing defaults, RGB565 -> RGB888 expansion, colour-bar palette and
// the sequencer state type.
package video_pkg;

    localparam int H_DISP_720P    = 1280;
    localparam int H_FP_720P      = 110;
    localparam int H_SYNC_720P    = 40;
    localparam int H_BP_720P      = 220;
    localparam int V_DISP_720P    = 720;
    localparam int V_FP_720P      = 5;
    localparam int V_SYNC_720P    = 5;
    localparam int V_BP_720P      = 20;
    localparam int FIFO_DEPTH_DEF = 2048;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_RUN  = 1'b1
    } vot_state_e;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    // Replicate the top bits into the new LSBs so full scale maps to 0xFF.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/video_out_timing_if.sv
// video_out_timing_if: pixel stream input, display timing output and status.
// master = upstream/system side, slave = the timing block.
interface video_out_timing_if #(
    parameter int LVL_W = 12
);
    logic [15:0]      in_data;
    logic             in_valid;
    logic             in_vs;
    logic             test_en;
    logic [23:0]      vid_rgb;
    logic             vid_hs;
    logic             vid_vs;
    logic             vid_de;
    logic             locked;
    logic             underflow;
    logic             overflow;
    logic             sync_err;
    logic [LVL_W-1:0] fifo_level;

    modport master (
        output in_data, in_valid, in_vs, test_en,
        input  vid_rgb, vid_hs, vid_vs, vid_de, locked,
               underflow, overflow, sync_err, fifo_level
    );

    modport slave (
        input  in_data, in_valid, in_vs, test_en,
        output vid_rgb, vid_hs, vid_vs, vid_de, locked,
               underflow, overflow, sync_err, fifo_level
    );
endinterface

// File: rtl/video_out_timing_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data, word count and
// synchronous flush. Writes when full and reads when empty are ignored.
module sync_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 2048,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_wr_en,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    output logic [DW-1:0] o_rd_data,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [DW-1:0] r_rd_data;
    logic          w_wr;
    logic          w_rd;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_wr      = i_wr_en & ~o_full;
    assign w_rd      = i_rd_en & ~o_empty;
    assign o_count   = r_count;
    assign o_rd_data = r_rd_data;

    // Storage array, no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    // Registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_rd_data <= '0;
        else if (w_rd) r_rd_data <= r_mem[r_rd_ptr];
    end

    // Pointers and count; simultaneous read and write leave the count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/video_out_timing.sv
// video_out_timing: buffers aligned RGB565 lines and regenerates HS/VS/DE
// with 24-bit RGB, locked to the upstream end-of-frame pulse.
// Optional colour-bar generator: define VID_OUT_TESTPAT_EN.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_WAIT | not locked; counters held at 0 (free-run with bars),
//           | FIFO flushed, input discarded
//   ST_RUN  | locked; counters free-run, input buffered, in_vs checked
module video_out_timing
    import video_pkg::*;
#(
    parameter int H_DISP     = H_DISP_720P,
    parameter int H_FP       = H_FP_720P,
    parameter int H_SYNC     = H_SYNC_720P,
    parameter int H_BP       = H_BP_720P,
    parameter int V_DISP     = V_DISP_720P,
    parameter int V_FP       = V_FP_720P,
    parameter int V_SYNC     = V_SYNC_720P,
    parameter int V_BP       = V_BP_720P,
    parameter bit HS_POL     = 1'b1,
    parameter bit VS_POL     = 1'b1,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
)(
    input  logic              video_clk,
    input  logic              rst,
    video_out_timing_if.slave bus
);
    localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int LW    = $clog2(FIFO_DEPTH) + 1;

    vot_state_e    r_state;
    logic [HW-1:0] r_hc;
    logic [VW-1:0] r_vc;
    logic          r_locked, r_sync_err, r_underflow, r_overflow;
    logic          r_de1, r_hs1, r_vs1, r_und1;
    logic          r_de2, r_hs2, r_vs2;
    logic [23:0]   r_rgb;
    logic [23:0]   w_pix;
    logic          w_pat, w_run, w_active, w_hs_on, w_vs_on;
    logic          w_h_end, w_v_end, w_frame_end, w_flush;
    logic          w_full, w_empty, w_wr_en, w_rd_en;
    logic [15:0]   w_rd_data;
    logic [LW-1:0] w_level;

`ifdef VID_OUT_TESTPAT_EN
    localparam int BAR_W = H_DISP / 8;
    logic [HW-1:0] r_bar_cnt;
    logic [2:0]    r_bar_idx;
    logic [2:0]    r_bar1;
    logic          r_pat1;
    logic          w_hc_zero_nxt;
    assign w_pat = bus.test_en;
`else
    logic w_unused_test_en;
    assign w_pat            = 1'b0;
    assign w_unused_test_en = bus.test_en;
`endif

    assign w_h_end     = (r_hc == HW'(H_TOT - 1));
    assign w_v_end     = (r_vc == VW'(V_TOT - 1));
    assign w_frame_end = w_h_end && (r_vc == VW'(V_DISP - 1));
    assign w_run       = (r_state == ST_RUN) || w_pat;
    assign w_active    = w_run && (r_hc < HW'(H_DISP)) && (r_vc < VW'(V_DISP));
    assign w_hs_on     = w_run && (r_hc >= HW'(H_DISP + H_FP))
                               && (r_hc <  HW'(H_DISP + H_FP + H_SYNC));
    assign w_vs_on     = w_run && (r_vc >= VW'(V_DISP + V_FP))
                               && (r_vc <  VW'(V_DISP + V_FP + V_SYNC));
    assign w_flush     = (r_state == ST_WAIT);
    assign w_wr_en     = (r_state == ST_RUN) && bus.in_valid;
    assign w_rd_en     = w_active && !w_empty && !w_pat;

    sync_fifo #(.DW(16), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (video_clk),
        .rst       (rst),
        .i_flush   (w_flush),
        .i_wr_en   (w_wr_en),
        .i_wr_data (bus.in_data),
        .i_rd_en   (w_rd_en),
        .o_rd_data (w_rd_data),
        .o_count   (w_level),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Sequencer: lock on in_vs, run the raster counters, flag misplaced in_vs.
    // A reload lands on the first blanking line so the FIFO can refill.
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_WAIT;
            r_hc       <= '0;
            r_vc       <= '0;
            r_locked   <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            if (bus.in_vs) begin
                r_state  <= ST_RUN;
                r_locked <= 1'b1;
                r_hc     <= '0;
                r_vc     <= VW'(V_DISP);
                if (r_state == ST_RUN && !w_frame_end) r_sync_err <= 1'b1;
            end else if (w_run) begin
                if (w_h_end) begin
                    r_hc <= '0;
                    r_vc <= w_v_end ? '0 : r_vc + 1'b1;
                end else begin
                    r_hc <= r_hc + 1'b1;
                end
            end else begin
                r_hc <= '0;
                r_vc <= '0;
            end
        end
    end

`ifdef VID_OUT_TESTPAT_EN
    assign w_hc_zero_nxt = bus.in_vs || w_h_end || !w_run;

    // Bar index tracks hc via a down-counter that reloads every BAR_W pixels.
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            r_bar_idx <= '0;
            r_bar_cnt <= HW'(BAR_W - 1);
        end else if (w_hc_zero_nxt) begin
            r_bar_idx <= '0;
            r_bar_cnt <= HW'(BAR_W - 1);
        end else if (r_bar_cnt == '0) begin
            r_bar_idx <= r_bar_idx + 1'b1;
            r_bar_cnt <= HW'(BAR_W - 1);
        end else begin
            r_bar_cnt <= r_bar_cnt - 1'b1;
        end
    end
`endif

    // Sticky error flags; only rst clears them.
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_active && !w_pat && w_empty)               r_underflow <= 1'b1;
            if (r_state == ST_RUN && bus.in_valid && w_full) r_overflow  <= 1'b1;
        end
    end

    // Output pixel select: bars, blank on underflow, else expanded FIFO word.
    always_comb begin
        w_pix = rgb565_to_888(w_rd_data);
        if (!r_de1 || r_und1) w_pix = '0;
`ifdef VID_OUT_TESTPAT_EN
        if (r_de1 && r_pat1) w_pix = bar_color(r_bar1);
`endif
    end

    // Two-stage pipeline: stage 1 aligns with the FIFO read, stage 2 drives pins.
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            r_de1  <= 1'b0;
            r_hs1  <= ~HS_POL;
            r_vs1  <= ~VS_POL;
            r_und1 <= 1'b0;
            r_de2  <= 1'b0;
            r_hs2  <= ~HS_POL;
            r_vs2  <= ~VS_POL;
            r_rgb  <= '0;
`ifdef VID_OUT_TESTPAT_EN
            r_pat1 <= 1'b0;
            r_bar1 <= '0;
`endif
        end else begin
            r_de1  <= w_active;
            r_hs1  <= w_hs_on ? HS_POL : ~HS_POL;
            r_vs1  <= w_vs_on ? VS_POL : ~VS_POL;
            r_und1 <= w_active && !w_pat && w_empty;
            r_de2  <= r_de1;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
            r_rgb  <= w_pix;
`ifdef VID_OUT_TESTPAT_EN
            r_pat1 <= w_pat;
            r_bar1 <= r_bar_idx;
`endif
        end
    end

    assign bus.vid_rgb    = r_rgb;
    assign bus.vid_hs     = r_hs2;
    assign bus.vid_vs     = r_vs2;
    assign bus.vid_de     = r_de2;
    assign bus.locked     = r_locked;
    assign bus.underflow  = r_underflow;
    assign bus.overflow   = r_overflow;
    assign bus.sync_err   = r_sync_err;
    assign bus.fifo_level = w_level;
endmodule

// File: tb/tb_video_out_timing.sv
// tb_video_out_timing: scoreboard bench for video_out_timing on a reduced
// raster (16x6 active, 24x10 total) with a 16-word FIFO.
module tb_video_out_timing;
    localparam int H_DISP = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
    localparam int V_DISP = 6,  V_FP = 1, V_SYNC = 1, V_BP = 2;
    localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int F     = H_TOT * V_TOT;
    localparam int K1    = (V_TOT - V_DISP) * H_TOT;
    localparam int FIFO_DEPTH = 16;
    localparam int LVL_W = 5;

    logic video_clk = 1'b0;
    logic rst;

    video_out_timing_if #(.LVL_W(LVL_W)) bus();

    video_out_timing #(
        .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(1'b1), .VS_POL(1'b1), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .video_clk (video_clk),
        .rst       (rst),
        .bus       (bus)
    );

    always #5 video_clk = ~video_clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [23:0] sb_q [$];

    bit   mon_en = 0;
    int   cyc = 0, de_cnt = 0, last_hs_rise = 0, lines_since_vs = 0;
    bit   hs_seen = 0, vs_seen = 0;
    logic prev_hs = 1'b0, prev_vs = 1'b0;
    logic [23:0] mon_exp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mkword(input int l, input int p);
        logic [31:0] lv, pv;
        lv = l;
        pv = p;
        return {lv[4:0], pv[5:0], ~lv[4:0]};
    endfunction

    function automatic logic [23:0] exp565(input logic [15:0] w);
        logic [4:0] r, b;
        logic [5:0] g;
        r = w[15:11];
        g = w[10:5];
        b = w[4:0];
        return {r, r[4:2], g, g[5:4], b, b[4:2]};
    endfunction

    // Output monitor: pops expected pixels on DE and checks raster geometry.
    always @(negedge video_clk) begin
        cyc++;
        if (mon_en) begin
            if (bus.vid_de) begin
                de_cnt++;
                if (sb_q.size() > 0) begin
                    mon_exp = sb_q.pop_front();
                    chk("pixel", bus.vid_rgb, mon_exp);
                end
            end
            if (bus.vid_hs && !prev_hs) begin
                if (hs_seen)     chk("h_period", cyc - last_hs_rise, H_TOT);
                if (de_cnt != 0) chk("de_per_line", de_cnt, H_DISP);
                de_cnt = 0;
                hs_seen = 1;
                last_hs_rise = cyc;
                lines_since_vs++;
            end
            if (!bus.vid_hs && prev_hs && hs_seen) chk("hs_width", cyc - last_hs_rise, H_SYNC);
            if (bus.vid_vs && !prev_vs) begin
                if (vs_seen) chk("v_lines", lines_since_vs, V_TOT);
                vs_seen = 1;
                lines_since_vs = 0;
            end
        end
        prev_hs = bus.vid_hs;
        prev_vs = bus.vid_vs;
    end

    task automatic mon_reset();
        mon_en = 0;
        de_cnt = 0;
        hs_seen = 0;
        vs_seen = 0;
        lines_since_vs = 0;
        sb_q.delete();
    endtask

    task automatic do_reset();
        bus.in_valid = 0;
        bus.in_vs = 0;
        bus.in_data = '0;
        rst = 1;
        @(negedge video_clk);
        rst = 0;
        @(negedge video_clk);
    endtask

    task automatic lock();
        bus.in_vs = 1;
        @(negedge video_clk);
        bus.in_vs = 0;
    endtask

    // Writes nlines x nper words, throttled on fifo_level, pushing expectations.
    task automatic feed(input int nlines, input int nper);
        int to;
        to = 0;
        for (int l = 0; l < nlines; l++) begin
            for (int p = 0; p < nper; p++) begin
                int g;
                logic [15:0] w;
                g = 0;
                bus.in_valid = 0;
                while (int'(bus.fifo_level) >= FIFO_DEPTH && g < 1000) begin
                    @(negedge video_clk);
                    g++;
                end
                if (g >= 1000) to++;
                w = mkword(l, p);
                bus.in_data = w;
                bus.in_valid = 1;
                sb_q.push_back(exp565(w));
                @(negedge video_clk);
            end
        end
        bus.in_valid = 0;
        chk("feed_timeouts", to, 0);
    endtask

    initial begin
        int n, first_de, g;
        logic [23:0] tp_pix [H_DISP];

        bus.in_data = '0;
        bus.in_valid = 0;
        bus.in_vs = 0;
        bus.test_en = 0;
        rst = 1;
        repeat (3) @(negedge video_clk);
        chk("rst_locked", bus.locked, 0);
        chk("rst_de", bus.vid_de, 0);
        chk("rst_hs", bus.vid_hs, 0);
        chk("rst_vs", bus.vid_vs, 0);
        chk("rst_rgb", bus.vid_rgb, 0);
        chk("rst_level", bus.fifo_level, 0);
        rst = 0;

        // Idle with a stream present but no lock: words discarded, no timing.
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1;
            bus.in_data = 16'(i + 1);
            @(negedge video_clk);
        end
        bus.in_valid = 0;
        @(negedge video_clk);
        chk("wait_level", bus.fifo_level, 0);
        chk("wait_locked", bus.locked, 0);
        chk("wait_de", bus.vid_de, 0);
        chk("wait_hs", bus.vid_hs, 0);

        // Lock and replay a full frame, then the normal end-of-frame in_vs.
        mon_reset();
        mon_en = 1;
        lock();
        chk("lock_locked", bus.locked, 1);
        first_de = -1;
        fork
            feed(V_DISP, H_DISP);
            begin
                n = 0;
                while (n < F + 72) begin
                    if (first_de < 0 && bus.vid_de) first_de = n;
                    if (n == F - 1) bus.in_vs = 1;
                    @(negedge video_clk);
                    n++;
                    bus.in_vs = 0;
                end
            end
        join
        mon_en = 0;
        chk("first_de_lat", first_de, K1 + 2);
        chk("replay_sb_empty", sb_q.size(), 0);
        chk("replay_underflow", bus.underflow, 0);
        chk("replay_overflow", bus.overflow, 0);
        chk("replay_sync_err", bus.sync_err, 0);
        chk("replay_locked", bus.locked, 1);

        // Starved line: 12 of 16 words for line 0.
        do_reset();
        mon_reset();
        mon_en = 1;
        lock();
        feed(1, 12);
        for (int i = 0; i < 4; i++) sb_q.push_back(24'h000000);
        chk("starve_uf_pre", bus.underflow, 0);
        g = 0;
        while (sb_q.size() > 0 && g < 500) begin
            @(negedge video_clk);
            g++;
        end
        chk("starve_drained", sb_q.size(), 0);
        repeat (3) @(negedge video_clk);
        chk("starve_uf", bus.underflow, 1);
        repeat (50) @(negedge video_clk);
        chk("starve_uf_sticky", bus.underflow, 1);
        mon_en = 0;

        // Overflow in blanking, then asynchronous reset mid-frame.
        do_reset();
        mon_reset();
        lock();
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            bus.in_valid = 1;
            bus.in_data = 16'(i);
            @(negedge video_clk);
        end
        bus.in_valid = 0;
        chk("ovf_level_full", bus.fifo_level, FIFO_DEPTH);
        chk("ovf_flag_pre", bus.overflow, 0);
        bus.in_valid = 1;
        @(negedge video_clk);
        bus.in_valid = 0;
        chk("ovf_level", bus.fifo_level, FIFO_DEPTH);
        chk("ovf_flag", bus.overflow, 1);
        rst = 1;
        #1;
        chk("arst_locked", bus.locked, 0);
        chk("arst_overflow", bus.overflow, 0);
        chk("arst_level", bus.fifo_level, 0);
        chk("arst_hs", bus.vid_hs, 0);
        @(negedge video_clk);
        rst = 0;

        // Early in_vs at vc=2, hc=5.
        do_reset();
        lock();
        repeat (K1 + 2 * H_TOT + 5) @(negedge video_clk);
        chk("early_vc_pre", dut.r_vc, 2);
        chk("early_hc_pre", dut.r_hc, 5);
        chk("early_err_pre", bus.sync_err, 0);
        bus.in_vs = 1;
        @(negedge video_clk);
        bus.in_vs = 0;
        chk("early_sync_err", bus.sync_err, 1);
        chk("early_vc", dut.r_vc, V_DISP);
        chk("early_hc", dut.r_hc, 0);

`ifdef VID_OUT_TESTPAT_EN
        // Colour bars while unlocked.
        bus.test_en = 1;
        do_reset();
        g = 0;
        while (!bus.vid_de && g < 500) begin
            @(negedge video_clk);
            g++;
        end
        chk("tp_de_seen", bus.vid_de, 1);
        for (int i = 0; i < H_DISP; i++) begin
            tp_pix[i] = bus.vid_rgb;
            @(negedge video_clk);
        end
        chk("tp_pix0", tp_pix[0], 24'hFFFFFF);
        chk("tp_pix_bar1", tp_pix[H_DISP / 8], 24'hFFFF00);
        chk("tp_pix_last", tp_pix[H_DISP - 1], 24'h000000);
        chk("tp_locked", bus.locked, 0);
        chk("tp_underflow", bus.underflow, 0);
        bus.test_en = 0;
`else
        tp_pix[0] = '0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
